// File: rtl/des_key_schedule_if.sv
// Key-load / subkey bus between the controlling logic and des_key_schedule.
//   key     : 64-bit DES key, bit 63 = DES bit 1 (parity bits ignored)
//   key_en  : load strobe, accepted only while busy = 0
//   decrypt : 0 = encrypt slot order, 1 = reversed slot order
//   subkeys : 16 x 48-bit slots, slot i at [48*i+47:48*i]
//   key_rdy : all 16 slots hold a complete schedule
//   busy    : generation in progress
interface des_key_schedule_if;
  localparam int unsigned KEY_W  = 64;
  localparam int unsigned SKS_W  = 768;

  logic [KEY_W-1:0] key;
  logic             key_en;
  logic             decrypt;
  logic [SKS_W-1:0] subkeys;
  logic             key_rdy;
  logic             busy;

  // Controller side: supplies the key, consumes the schedule
  modport master (
    output key, key_en, decrypt,
    input  subkeys, key_rdy, busy
  );

  // Key schedule side
  modport slave (
    input  key, key_en, decrypt,
    output subkeys, key_rdy, busy
  );
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into the sixteen 48-bit round
// subkeys, one per clock, into a flat bank tapped by the unrolled round
// pipeline. Decrypt order stores the same subkeys in reversed slots.
// Ports:
//   clk  : system clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : des_key_schedule_if.slave (key, key_en, decrypt in;
//          subkeys, key_rdy, busy out, all registered)
module des_key_schedule (
  input  logic                 clk,
  input  logic                 rstn,
  des_key_schedule_if.slave    bus
);

  localparam int unsigned N_ROUNDS = 16;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned SK_W     = 48;
  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CNT_W    = 4;

  // FIPS 46-3 PC-1 (DES bit numbers, 1 = MSB of key)
  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // FIPS 46-3 PC-2 (bit numbers into {C,D}, 1 = MSB of C)
  localparam int unsigned PC2_TAB [SK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // PC-1: 56 key bits without parity, pure wiring
  function automatic logic [CD_W-1:0] f_pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      o[6'(int'(CD_W) - 1 - i)] = k[6'(int'(KEY_W) - int'(PC1_TAB[i]))];
    end
    return o;
  endfunction

  // PC-2: 48 of the 56 rotated C/D bits, pure wiring
  function automatic logic [SK_W-1:0] f_pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] o;
    o = '0;
    for (int i = 0; i < int'(SK_W); i++) begin
      o[6'(int'(SK_W) - 1 - i)] = cd[6'(int'(CD_W) - int'(PC2_TAB[i]))];
    end
    return o;
  endfunction

  // Left rotate a 28-bit half by one or two positions
  function automatic logic [HALF_W-1:0] f_rotl(input logic [HALF_W-1:0] x,
                                              input logic            two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
               : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  state_t             r_state, w_state_nxt;
  logic [HALF_W-1:0]  r_c, r_d, w_c_nxt, w_d_nxt, w_c_rot, w_d_rot;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_rdy, w_rdy_nxt;
  logic [CD_W-1:0]    w_pc1;
  logic [SK_W-1:0]    w_pc2;
  logic               w_two;
  logic               w_slot_we;
  logic [CNT_W-1:0]   w_slot_idx;
  logic [SK_W-1:0]    r_slot [N_ROUNDS];
  logic [N_ROUNDS*SK_W-1:0] w_subkeys;

  // Single-position shifts occur on rounds 1, 2, 9 and 16
  assign w_two = !((r_cnt == CNT_W'(0)) || (r_cnt == CNT_W'(1)) ||
                   (r_cnt == CNT_W'(8)) || (r_cnt == CNT_W'(15)));

  assign w_pc1      = f_pc1(bus.key);
  assign w_c_rot    = f_rotl(r_c, w_two);
  assign w_d_rot    = f_rotl(r_d, w_two);
  assign w_pc2      = f_pc2({w_c_rot, w_d_rot});
  assign w_slot_idx = r_dir ? (CNT_W'(N_ROUNDS - 1) - r_cnt) : r_cnt;

  // Next-state and next-value logic
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_busy_nxt  = r_busy;
    w_rdy_nxt   = r_rdy;
    w_slot_we   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.key_en) begin
          w_state_nxt = S_GEN;
          w_c_nxt     = w_pc1[CD_W-1:HALF_W];
          w_d_nxt     = w_pc1[HALF_W-1:0];
          w_dir_nxt   = bus.decrypt;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_rdy_nxt   = 1'b0;
        end
      end
      S_GEN: begin
        // key_en is ignored here: the running schedule always completes
        w_c_nxt   = w_c_rot;
        w_d_nxt   = w_d_rot;
        w_slot_we = 1'b1;
        if (r_cnt == CNT_W'(N_ROUNDS - 1)) begin
          w_state_nxt = S_DONE;
          w_rdy_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, key halves, control and subkey bank
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b0;
      for (int i = 0; i < int'(N_ROUNDS); i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= w_busy_nxt;
      r_rdy   <= w_rdy_nxt;
      if (w_slot_we) begin
        r_slot[w_slot_idx] <= w_pc2;
      end
    end
  end

  // Flatten the bank: slot 0 in the low bits
  always_comb begin
    w_subkeys = '0;
    for (int g = 0; g < int'(N_ROUNDS); g++) begin
      w_subkeys[g*int'(SK_W) +: SK_W] = r_slot[g];
    end
  end

  assign bus.subkeys = w_subkeys;
  assign bus.key_rdy = r_rdy;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: reset, FIPS vector in both
// orders, parity/weak keys, random keys, busy collision and mid-run reset,
// all against a bit-numbered reference model of the DES key schedule.
module tb_des_key_schedule;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] FIPS_KEY    = 64'h133457799BBCDFF1;
  localparam logic [47:0] FIPS_K1     = 48'h1B02EFFC7072;
  localparam logic [47:0] FIPS_K16    = 48'hCB3D8B0E17F5;
  localparam logic [63:0] PARITY_MASK = 64'h0101010101010101;

  logic clk;
  logic rstn;
  int   n_pass;
  int   n_total;

  des_key_schedule_if u_if ();

  des_key_schedule u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  // Reference: DES bits numbered 1..N, rounds rotate by the cumulative shift
  function automatic logic [767:0] ref_sched(input logic [63:0] key, input logic dec);
    logic [767:0] res;
    logic         kb  [1:64];
    logic         cd  [1:56];
    logic         rot [1:56];
    logic [47:0]  sk;
    int           total;
    int           slot;
    res = '0;
    for (int n = 1; n <= 64; n++) kb[n] = key[64-n];
    for (int j = 1; j <= 56; j++) cd[j] = kb[PC1[j-1]];
    total = 0;
    for (int r = 1; r <= 16; r++) begin
      total = total + SHIFTS[r-1];
      for (int j = 1; j <= 28; j++) begin
        rot[j]      = cd[((j - 1 + total) % 28) + 1];
        rot[28 + j] = cd[28 + ((j - 1 + total) % 28) + 1];
      end
      sk = '0;
      for (int k = 1; k <= 48; k++) sk[48-k] = rot[PC2[k-1]];
      slot = dec ? (16 - r) : (r - 1);
      res[slot*48 +: 48] = sk;
    end
    return res;
  endfunction

  // Present a key for one clock edge; returns #1 after the accepting edge
  task automatic load(input logic [63:0] key, input logic dec);
    u_if.key     = key;
    u_if.decrypt = dec;
    u_if.key_en  = 1'b1;
    @(posedge clk); #1;
    u_if.key_en  = 1'b0;
  endtask

  // Bounded wait for key_rdy, counting edges
  task automatic wait_rdy(output int cycles);
    cycles = 0;
    while (u_if.key_rdy !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    n_total++;
    if ({u_if.subkeys, u_if.key_rdy, u_if.busy} !== 770'd0) begin
      $display("FAIL reset_outputs: got subkeys=%h rdy=%b busy=%b, want all 0",
               u_if.subkeys, u_if.key_rdy, u_if.busy);
    end else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_total++;
      if ({u_if.subkeys, u_if.key_rdy, u_if.busy} !== 770'd0) begin
        $display("FAIL reset_idle cycle %0d: got rdy=%b busy=%b, want all 0",
                 c, u_if.key_rdy, u_if.busy);
      end else n_pass++;
    end
  endtask

  task automatic test_fips_encrypt;
    logic [767:0] exp;
    logic [767:0] got;
    int           busy_cycles;
    exp = ref_sched(FIPS_KEY, 1'b0);
    load(FIPS_KEY, 1'b0);
    busy_cycles = 0;
    while (u_if.busy === 1'b1 && busy_cycles < 40) begin
      n_total++;
      if (u_if.key_rdy !== 1'b0) begin
        $display("FAIL enc_rdy_while_busy: got %b want 0", u_if.key_rdy);
      end else n_pass++;
      @(posedge clk); #1;
      busy_cycles++;
    end
    n_total++;
    if (busy_cycles !== 16) begin
      $display("FAIL enc_busy_len: got %0d want 16", busy_cycles);
    end else n_pass++;
    n_total++;
    if (u_if.key_rdy !== 1'b1) begin
      $display("FAIL enc_rdy_after: got %b want 1", u_if.key_rdy);
    end else n_pass++;
    got = u_if.subkeys;
    n_total++;
    if (got[47:0] !== FIPS_K1) begin
      $display("FAIL enc_slot0: got %h want %h", got[47:0], FIPS_K1);
    end else n_pass++;
    n_total++;
    if (got[767:720] !== FIPS_K16) begin
      $display("FAIL enc_slot15: got %h want %h", got[767:720], FIPS_K16);
    end else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (got[i*48 +: 48] !== exp[i*48 +: 48]) begin
        $display("FAIL enc_slot%0d: got %h want %h", i, got[i*48 +: 48], exp[i*48 +: 48]);
      end else n_pass++;
    end
    // DONE holds the schedule
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (u_if.subkeys !== exp || u_if.key_rdy !== 1'b1) begin
      $display("FAIL enc_hold: rdy=%b got %h want %h", u_if.key_rdy, u_if.subkeys, exp);
    end else n_pass++;
  endtask

  task automatic test_fips_decrypt;
    logic [767:0] enc;
    logic [767:0] got;
    int           cyc;
    enc = ref_sched(FIPS_KEY, 1'b0);
    load(FIPS_KEY, 1'b1);
    wait_rdy(cyc);
    n_total++;
    if (cyc !== 16) begin
      $display("FAIL dec_latency: got %0d want 16", cyc);
    end else n_pass++;
    got = u_if.subkeys;
    n_total++;
    if (got[47:0] !== FIPS_K16) begin
      $display("FAIL dec_slot0: got %h want %h", got[47:0], FIPS_K16);
    end else n_pass++;
    n_total++;
    if (got[767:720] !== FIPS_K1) begin
      $display("FAIL dec_slot15: got %h want %h", got[767:720], FIPS_K1);
    end else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (got[i*48 +: 48] !== enc[(15-i)*48 +: 48]) begin
        $display("FAIL dec_slot%0d: got %h want %h", i, got[i*48 +: 48], enc[(15-i)*48 +: 48]);
      end else n_pass++;
    end
  endtask

  task automatic test_parity_weak;
    logic [63:0]  keys [3];
    logic [767:0] exps [3];
    logic [63:0]  k;
    logic [767:0] exp;
    int           cyc;
    keys[0] = 64'h0101010101010101; exps[0] = '0;
    keys[1] = 64'h0;                exps[1] = '0;
    keys[2] = 64'hFEFEFEFEFEFEFEFE; exps[2] = '1;
    for (int t = 0; t < 3; t++) begin
      load(keys[t], 1'($urandom_range(0, 1)));
      wait_rdy(cyc);
      n_total++;
      if (cyc !== 16 || u_if.subkeys !== exps[t]) begin
        $display("FAIL weak_key%0d: cyc=%0d got %h want %h", t, cyc, u_if.subkeys, exps[t]);
      end else n_pass++;
    end
    for (int t = 0; t < 3; t++) begin
      k   = {$urandom, $urandom};
      exp = ref_sched(k, 1'b0);
      load(k ^ (PARITY_MASK & {$urandom, $urandom}), 1'b0);
      wait_rdy(cyc);
      n_total++;
      if (u_if.subkeys !== exp) begin
        $display("FAIL parity_flip%0d: got %h want %h", t, u_if.subkeys, exp);
      end else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [63:0]  k;
    logic         d;
    logic [767:0] exp;
    int           cyc;
    for (int t = 0; t < 8; t++) begin
      k   = {$urandom, $urandom};
      d   = 1'($urandom_range(0, 1));
      exp = ref_sched(k, d);
      load(k, d);
      wait_rdy(cyc);
      n_total++;
      if (cyc !== 16) begin
        $display("FAIL rand%0d_latency: got %0d want 16", t, cyc);
      end else n_pass++;
      n_total++;
      if (u_if.subkeys !== exp) begin
        $display("FAIL rand%0d_sched: key=%h dec=%b got %h want %h", t, k, d, u_if.subkeys, exp);
      end else n_pass++;
    end
  endtask

  task automatic test_busy_collision;
    logic [63:0]  ka;
    logic [63:0]  kb;
    logic [767:0] exp_a;
    logic [767:0] exp_b;
    int           cyc;
    ka    = {$urandom, $urandom};
    kb    = ~ka;
    exp_a = ref_sched(ka, 1'b0);
    exp_b = ref_sched(kb, 1'b1);
    load(ka, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    load(kb, 1'b1);
    wait_rdy(cyc);
    n_total++;
    if (cyc + 5 !== 16) begin
      $display("FAIL coll_latency: got %0d want 16", cyc + 5);
    end else n_pass++;
    n_total++;
    if (u_if.subkeys !== exp_a) begin
      $display("FAIL coll_keeps_a: got %h want %h", u_if.subkeys, exp_a);
    end else n_pass++;
    load(kb, 1'b1);
    n_total++;
    if (u_if.key_rdy !== 1'b0 || u_if.busy !== 1'b1) begin
      $display("FAIL coll_reload_rdy: got rdy=%b busy=%b want rdy=0 busy=1", u_if.key_rdy, u_if.busy);
    end else n_pass++;
    wait_rdy(cyc);
    n_total++;
    if (cyc !== 16 || u_if.subkeys !== exp_b) begin
      $display("FAIL coll_b_sched: cyc=%0d got %h want %h", cyc, u_if.subkeys, exp_b);
    end else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [63:0]  k;
    logic [767:0] exp;
    int           cyc;
    k = {$urandom, $urandom};
    load(k, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({u_if.subkeys, u_if.key_rdy, u_if.busy} !== 770'd0) begin
      $display("FAIL mid_reset: got rdy=%b busy=%b subkeys=%h want all 0",
               u_if.key_rdy, u_if.busy, u_if.subkeys);
    end else n_pass++;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({u_if.subkeys, u_if.key_rdy, u_if.busy} !== 770'd0) begin
      $display("FAIL mid_reset_idle: got rdy=%b busy=%b want 0 0", u_if.key_rdy, u_if.busy);
    end else n_pass++;
    k   = {$urandom, $urandom};
    exp = ref_sched(k, 1'b1);
    load(k, 1'b1);
    wait_rdy(cyc);
    n_total++;
    if (cyc !== 16 || u_if.subkeys !== exp) begin
      $display("FAIL mid_reset_reload: cyc=%0d got %h want %h", cyc, u_if.subkeys, exp);
    end else n_pass++;
  endtask

  initial begin
    clk          = 1'b0;
    rstn         = 1'b0;
    n_pass       = 0;
    n_total      = 0;
    u_if.key     = '0;
    u_if.key_en  = 1'b0;
    u_if.decrypt = 1'b0;
    test_reset();
    test_fips_encrypt();
    test_fips_decrypt();
    test_parity_weak();
    test_random();
    test_busy_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
